// File: rtl/fp_alu_pkg.sv
// Shared FP ALU definitions: opcode constants, rounding-mode encodings,
// issue-sequencer state and small decode helpers.
package fp_alu_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 5;
    localparam int RM_W = 3;

    localparam logic [OP_W-1:0] OP_FADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_FSUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_FMUL  = 5'd2;
    localparam logic [OP_W-1:0] OP_FDIV  = 5'd3;
    localparam logic [OP_W-1:0] OP_FSQRT = 5'd4;
    localparam logic [OP_W-1:0] OP_FMIN  = 5'd5;
    localparam logic [OP_W-1:0] OP_FMAX  = 5'd6;
    localparam logic [OP_W-1:0] OP_FCVT  = 5'd7;

    localparam logic [RM_W-1:0] RM_RNE = 3'd0;
    localparam logic [RM_W-1:0] RM_RTZ = 3'd1;
    localparam logic [RM_W-1:0] RM_RDN = 3'd2;
    localparam logic [RM_W-1:0] RM_RUP = 3'd3;
    localparam logic [RM_W-1:0] RM_RMM = 3'd4;
    localparam logic [RM_W-1:0] RM_DYN = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

    // Operand bundle held on the ALU inputs for the duration of an op
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] conv;
        logic [RM_W-1:0] rm;
    } alu_issue_t;

    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op == OP_FDIV) || (op == OP_FSQRT);
    endfunction

    // Encodings 5 and 6 are reserved; 7 (DYN) is only meaningful before resolution
    function automatic logic rm_is_illegal(input logic [RM_W-1:0] rm);
        return (rm == 3'd5) || (rm == 3'd6) || (rm == 3'd7);
    endfunction

endpackage

// File: rtl/fp_alu_issue_ctrl.sv
// Issue sequencer for the FP ALU: accepts one op, holds operands for the
// op-class latency, captures the ALU result and returns it over valid/ready.
module fp_alu_issue_ctrl
    import fp_alu_pkg::*;
#(
    parameter int LAT_SHORT = 2,
    parameter int LAT_LONG  = 16,
    parameter int CNT_W     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [XLEN-1:0] req_conv,
    input  logic [RM_W-1:0] req_rm,
    input  logic [RM_W-1:0] frm,
    output logic [XLEN-1:0] alu_rd1,
    output logic [XLEN-1:0] alu_rd2,
    output logic [XLEN-1:0] alu_conv,
    output logic [OP_W-1:0] alu_op,
    output logic [RM_W-1:0] alu_rm,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_illegal,
    output logic            busy
);

    localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(LAT_SHORT - 1);
    localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(LAT_LONG - 1);

    issue_state_e    state, state_nxt;
    alu_issue_t      issue_q;
    logic [CNT_W-1:0] cnt;
    logic [RM_W-1:0] rm_eff;
    logic            rm_bad;
    logic            accept;
    logic            cnt_done;

    assign rm_eff   = (req_rm == RM_DYN) ? frm : req_rm;
    assign rm_bad   = rm_is_illegal(rm_eff);
    assign accept   = req_valid && (state == ST_IDLE);
    assign cnt_done = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = rm_bad ? ST_RESP : ST_EXEC;
            ST_EXEC: if (cnt_done) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
    end

    // Operand registers only load on a legal accept, so the ALU inputs never
    // toggle while idle, waiting for a response, or on a rejected op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= '0;
            cnt     <= '0;
        end else if (accept && !rm_bad) begin
            issue_q.op   <= req_op;
            issue_q.rd1  <= req_rs1;
            issue_q.rd2  <= req_rs2;
            issue_q.conv <= req_conv;
            issue_q.rm   <= rm_eff;
            cnt          <= is_long_op(req_op) ? LOAD_LONG : LOAD_SHORT;
        end else if (state == ST_EXEC && !cnt_done) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
        end else if (accept && rm_bad) begin
            rsp_data    <= '0;
            rsp_illegal <= 1'b1;
        end else if (state == ST_EXEC && cnt_done) begin
            rsp_data    <= alu_result;
            rsp_illegal <= 1'b0;
        end
    end

    assign alu_op   = issue_q.op;
    assign alu_rd1  = issue_q.rd1;
    assign alu_rd2  = issue_q.rd2;
    assign alu_conv = issue_q.conv;
    assign alu_rm   = issue_q.rm;

endmodule
